ysyx_22041211_pipe_buf: RTL

//  Parametrised valid/ready FIFO placed between core stages (IFU->IDU, IDU->EXU, EXU->LSU, LSU->WB).

---
 rtl/ysyx_22041211_pipe_buf.sv | 109 ++++++++++
 1 files changed

// File: rtl/ysyx_22041211_pipe_buf.sv
// ysyx_22041211_pipe_buf: parametrised valid/ready FIFO between core pipeline stages.
// One instance sits on each stage boundary and carries the packed stage bundle.
// A redirect flush drops every held entry at the next edge; the asynchronous
// active-low reset drops them immediately.
// Optional feature macro: YSYX_22041211_PIPE_BUF_BYPASS_EN
//   defined   -> cut-through from in_* to out_* while the buffer is empty
//   undefined -> outputs come from storage only, minimum latency one cycle
module ysyx_22041211_pipe_buf #(
    parameter int DATA_LEN = 32,
    parameter int DEPTH    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_LEN-1:0]          in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_LEN-1:0]          out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Entry storage; contents are never reset, occupancy tracking alone decides validity.
    logic [DATA_LEN-1:0] mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic empty;
    logic full;
    logic cut_through;
    logic push;
    logic pop;
    logic store;
    logic retire;

    // Pointers wrap by explicit compare so any DEPTH works, not only powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Ready depends on occupancy only: no combinational path from out_ready_i,
    // so a pop while full does not open a slot in the same cycle.
    assign in_ready_o = ~full;

`ifdef YSYX_22041211_PIPE_BUF_BYPASS_EN
    // Empty buffer forwards the upstream payload straight through. Gated by rst
    // so the outputs keep their reset values while reset is held.
    assign cut_through = empty & in_valid_i & ~flush_i & rst;
`else
    assign cut_through = 1'b0;
`endif

    assign out_valid_o = (~empty | cut_through) & ~flush_i;
    assign out_data_o  = (~empty)    ? mem[rd_ptr] :
                         cut_through ? in_data_i   : '0;
    assign count_o     = count;

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i;

    // A cut-through entry consumed in the same cycle never touches storage.
    assign store  = push & ~(cut_through & out_ready_i);
    assign retire = pop & ~empty;

    // Write accepted payloads into the tail slot.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    // Pointer and occupancy state: reset and flush both empty the buffer, reset first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (retire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({store, retire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
